// File: rtl/jk_excite_driver.sv
// Computes J/K excitation from (present Q, target Q), drives a JK bank for one
// enable cycle, waits SETTLE cycles, then checks the bank against the target.
module jk_excite_driver #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          DC_POLICY = 1'b0,
  parameter int unsigned SETTLE    = 1
) (
  input  logic             clk,
  input  logic             cl,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_target,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             jk_en,
  output logic             done,
  output logic             err,
  output logic [7:0]       err_cnt
);

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned ERR_W   = 8;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_WAIT, S_CHECK} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   target_q, target_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   j_q, j_d, k_q, k_d;
  logic               jk_en_q, jk_en_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;

  logic [WIDTH-1:0]   exc_j_c, exc_k_c;
  logic               mismatch_c;

  // Don't-care side of each excitation pair takes the DC_POLICY value
  assign exc_j_c    = (~q_fb & in_target) | (q_fb & {WIDTH{DC_POLICY}});
  assign exc_k_c    = (q_fb & ~in_target) | (~q_fb & {WIDTH{DC_POLICY}});
  assign mismatch_c = (q_fb != target_q);

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    cnt_d     = cnt_q;
    j_d       = '0;
    k_d       = '0;
    jk_en_d   = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          target_d = in_target;
          j_d      = exc_j_c;
          k_d      = exc_k_c;
          jk_en_d  = 1'b1;
          state_d  = S_DRIVE;
        end
      end
      S_DRIVE: begin
        cnt_d   = CNT_W'(SETTLE);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        // Result is registered on the way into CHECK so done/err show there
        if (cnt_q == CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = S_CHECK;
          done_d  = 1'b1;
          err_d   = mismatch_c;
          if (mismatch_c && (err_cnt_q != ERR_MAX)) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
          end
        end
      end
      S_CHECK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge cl) begin
    if (!cl) begin
      state_q   <= S_IDLE;
      target_q  <= '0;
      cnt_q     <= '0;
      j_q       <= '0;
      k_q       <= '0;
      jk_en_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      cnt_q     <= cnt_d;
      j_q       <= j_d;
      k_q       <= k_d;
      jk_en_q   <= jk_en_d;
      done_q    <= done_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign in_ready = (state_q == S_IDLE);
  assign j        = j_q;
  assign k        = k_q;
  assign jk_en    = jk_en_q;
  assign done     = done_q;
  assign err      = err_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_jk_excite_driver.sv
// Scoreboard bench: two drivers (DC_POLICY=0/SETTLE=2 and DC_POLICY=1/SETTLE=1),
// each feeding a behavioural JK bank that can have stuck-at-0 bits.
module tb_jk_excite_driver;

  logic       clk = 1'b0;
  logic [1:0] cl = 2'b11;
  logic [1:0] in_valid = 2'b00;
  logic [1:0] in_ready, jk_en, done, err;
  logic [3:0] in_target [2];
  logic [3:0] bank [2];
  logic [3:0] ld_val [2];
  logic [3:0] stuck [2];
  logic [1:0] bank_ld = 2'b00;
  logic [3:0] j [2];
  logic [3:0] k [2];
  logic [7:0] err_cnt [2];

  typedef struct { int d; logic [3:0] j; logic [3:0] k; int cyc; } jk_exp_t;
  typedef struct { int d; logic err; logic [7:0] cnt; int cyc; } dn_exp_t;

  jk_exp_t jk_q[$];
  dn_exp_t dn_q[$];
  int      settle_of [2] = '{2, 1};
  int      exp_cnt [2]   = '{0, 0};
  int      cyc = 0;
  int      n_pass = 0;
  int      n_total = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  jk_excite_driver #(.WIDTH(4), .DC_POLICY(1'b0), .SETTLE(2)) dut_a (
    .clk(clk), .cl(cl[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_target(in_target[0]), .q_fb(bank[0]), .j(j[0]), .k(k[0]),
    .jk_en(jk_en[0]), .done(done[0]), .err(err[0]), .err_cnt(err_cnt[0]));

  jk_excite_driver #(.WIDTH(4), .DC_POLICY(1'b1), .SETTLE(1)) dut_b (
    .clk(clk), .cl(cl[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_target(in_target[1]), .q_fb(bank[1]), .j(j[1]), .k(k[1]),
    .jk_en(jk_en[1]), .done(done[1]), .err(err[1]), .err_cnt(err_cnt[1]));

  // Behavioural JK bank clocked only while jk_en is high
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (bank_ld[d]) bank[d] <= ld_val[d] & ~stuck[d];
      else if (jk_en[d]) bank[d] <= ((j[d] & ~bank[d]) | (~k[d] & bank[d])) & ~stuck[d];
    end
  end

  function automatic void chk(input string nm, input int d, input logic [31:0] act,
                              input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d: got %0h expected %0h (cycle %0d)", nm, d, act, exp, cyc);
  endfunction

  // Monitor: pops expectations whenever a DUT presents jk_en or done
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (cl[d]) begin
        if (jk_en[d]) begin
          int idx = -1;
          for (int i = 0; i < jk_q.size(); i++) if (idx < 0 && jk_q[i].d == d) idx = i;
          if (idx < 0) chk("spurious_jk_en", d, 32'(jk_en[d]), 32'd0);
          else begin
            chk("j", d, 32'(j[d]), 32'(jk_q[idx].j));
            chk("k", d, 32'(k[d]), 32'(jk_q[idx].k));
            chk("jk_en_cycle", d, 32'(cyc), 32'(jk_q[idx].cyc));
            jk_q.delete(idx);
          end
        end else begin
          chk("jk_idle_zero", d, {24'd0, j[d], k[d]}, 32'd0);
        end
        if (done[d]) begin
          int idx = -1;
          for (int i = 0; i < dn_q.size(); i++) if (idx < 0 && dn_q[i].d == d) idx = i;
          if (idx < 0) chk("spurious_done", d, 32'(done[d]), 32'd0);
          else begin
            chk("err", d, 32'(err[d]), 32'(dn_q[idx].err));
            chk("err_cnt", d, 32'(err_cnt[d]), 32'(dn_q[idx].cnt));
            chk("done_cycle", d, 32'(cyc), 32'(dn_q[idx].cyc));
            dn_q.delete(idx);
          end
        end else begin
          chk("err_without_done", d, 32'(err[d]), 32'd0);
        end
      end
    end
  end

  task automatic load_bank(input int d, input logic [3:0] v);
    @(negedge clk);
    ld_val[d]  = v;
    bank_ld[d] = 1'b1;
    @(negedge clk);
    bank_ld[d] = 1'b0;
  endtask

  // Presents a target (valid stays high afterwards) and pushes the expected response
  task automatic send(input int d, input logic [3:0] tgt, input logic [3:0] ej,
                      input logic [3:0] ek, input logic eerr, output int waited);
    jk_exp_t je;
    dn_exp_t de;
    waited = 0;
    @(negedge clk);
    in_valid[d]  = 1'b1;
    in_target[d] = tgt;
    while (!in_ready[d] && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready[d]) begin
      chk("accept_timeout", d, 32'(in_ready[d]), 32'd1);
    end else begin
      if (eerr && exp_cnt[d] < 255) exp_cnt[d]++;
      je.d = d; je.j = ej; je.k = ek; je.cyc = cyc + 1;
      de.d = d; de.err = eerr; de.cnt = 8'(exp_cnt[d]); de.cyc = cyc + 2 + settle_of[d];
      jk_q.push_back(je);
      dn_q.push_back(de);
      @(posedge clk);
    end
  endtask

  task automatic idle(input int d);
    @(negedge clk);
    in_valid[d] = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while ((jk_q.size() != 0 || dn_q.size() != 0) && w < 200) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    chk("drain_pending", 0, 32'(jk_q.size() + dn_q.size()), 32'd0);
  endtask

  task automatic chk_reset_vals(input int d);
    chk("rst_in_ready", d, 32'(in_ready[d]), 32'd1);
    chk("rst_j_k", d, {24'd0, j[d], k[d]}, 32'd0);
    chk("rst_jk_en", d, 32'(jk_en[d]), 32'd0);
    chk("rst_done_err", d, {30'd0, done[d], err[d]}, 32'd0);
    chk("rst_err_cnt", d, 32'(err_cnt[d]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int w, w2, w3;
    int acc [3];
    for (int d = 0; d < 2; d++) begin
      in_target[d] = '0; ld_val[d] = '0; stuck[d] = '0;
    end
    #1 cl = 2'b00;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) chk_reset_vals(d);
    cl = 2'b11;

    // DC_POLICY=0: 0101 -> 0011
    load_bank(0, 4'b0101);
    send(0, 4'b0011, 4'b0010, 4'b0100, 1'b0, w);
    idle(0);
    drain();
    chk("bank_a_result", 0, 32'(bank[0]), 32'h3);

    // DC_POLICY=1: same vector, don't-cares become 1
    load_bank(1, 4'b0101);
    send(1, 4'b0011, 4'b0111, 4'b1110, 1'b0, w);
    idle(1);
    drain();
    chk("bank_b_result", 1, 32'(bank[1]), 32'h3);

    // Bit 2 stuck at 0: target unreachable
    stuck[0] = 4'b0100;
    load_bank(0, 4'b0000);
    send(0, 4'b0100, 4'b0100, 4'b0000, 1'b1, w);
    idle(0);
    drain();

    // Asynchronous reset while in WAIT abandons the transaction
    stuck[0] = 4'b0000;
    load_bank(0, 4'b0000);
    send(0, 4'b1111, 4'b1111, 4'b0000, 1'b0, w);
    idle(0);
    @(posedge clk);
    #2 cl[0] = 1'b0;
    #1 chk_reset_vals(0);
    for (int i = dn_q.size() - 1; i >= 0; i--) if (dn_q[i].d == 0) dn_q.delete(i);
    for (int i = jk_q.size() - 1; i >= 0; i--) if (jk_q[i].d == 0) jk_q.delete(i);
    exp_cnt[0] = 0;
    repeat (2) @(negedge clk);
    cl[0] = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_reset_err_cnt", 0, 32'(err_cnt[0]), 32'd0);
    drain();

    // Back-to-back targets with in_valid held high (SETTLE=1)
    load_bank(1, 4'b0000);
    send(1, 4'b1010, 4'b1010, 4'b1111, 1'b0, w);
    acc[0] = cyc - 1;
    send(1, 4'b0110, 4'b1110, 4'b1101, 1'b0, w2);
    acc[1] = cyc - 1;
    send(1, 4'b0110, 4'b0110, 4'b1001, 1'b0, w3);
    acc[2] = cyc - 1;
    idle(1);
    chk("b2b_spacing_1", 1, 32'(acc[1] - acc[0]), 32'd4);
    chk("b2b_spacing_2", 1, 32'(acc[2] - acc[1]), 32'd4);
    chk("b2b_not_ready_1", 1, 32'(w2), 32'd3);
    chk("b2b_not_ready_2", 1, 32'(w3), 32'd3);
    drain();
    chk("b2b_bank", 1, 32'(bank[1]), 32'h6);

    // 260 failures: counter saturates at 255
    stuck[0] = 4'b0100;
    load_bank(0, 4'b0000);
    for (int i = 0; i < 260; i++) send(0, 4'b0100, 4'b0100, 4'b0000, 1'b1, w);
    idle(0);
    drain();
    chk("err_cnt_saturated", 0, 32'(err_cnt[0]), 32'd255);
    chk("other_err_cnt", 1, 32'(err_cnt[1]), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
